bcd_counter_nd: RTL and testbench

- Parametrised N-digit BCD up/down counter with a programmable modulus, synchronous load, cascade carry in/out and load-error flag.
- Drop-in successor for the team's 2-digit BCD counters in the timer and display datapaths; drives digit decoders directly.
- Wider counts use a single wide instance or cascaded instances (CO feeds the next stage's CI).

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_counter_nd_if.sv | 33 +++
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_counter_nd.sv | 138 +++++++++++++
 tb/tb_bcd_counter_nd.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the N-digit counter and its digit slices.
//   BCD_MAX_DIGIT : largest legal decimal digit (9)
//   bcd_digit_t   : one 4-bit BCD digit
//   bcd_valid()   : 1 when a digit is a legal decimal digit (0..9)
//   bcd_clamp()   : saturates an illegal digit (A..F) to 9
package bcd_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= BCD_MAX_DIGIT);
  endfunction

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit);
    return bcd_valid(digit) ? digit : BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_counter_nd_if.sv
// Signal bundle for bcd_counter_nd.
//   master : the controlling side; drives CE, CI, UP, LD, D, MAX and
//            observes Q, TC, CO, ERR.
//   slave  : the counter itself.
// There is no valid/ready handshake here: every control input is sampled
// on each rising clock edge, and LD/CE act only on the edge they are
// high for. TC and CO are combinational, Q and ERR are registered.
interface bcd_counter_nd_if #(
  parameter int DIGITS = 4
);

  logic                  CE;
  logic                  CI;
  logic                  UP;
  logic                  LD;
  logic [4*DIGITS-1:0]   D;
  logic [4*DIGITS-1:0]   MAX;
  logic [4*DIGITS-1:0]   Q;
  logic                  TC;
  logic                  CO;
  logic                  ERR;

  modport master (
    output CE, CI, UP, LD, D, MAX,
    input  Q, TC, CO, ERR
  );

  modport slave (
    input  CE, CI, UP, LD, D, MAX,
    output Q, TC, CO, ERR
  );

endinterface

// File: rtl/bcd_digit.sv
// One combinational BCD digit slice of the ripple incrementer/decrementer.
//   digit : current digit value (always 0..9)
//   up    : 1 = increment, 0 = decrement
//   cin   : carry (up) or borrow (down) request from the lower digit
//   nxt   : digit value after applying the request
//   cout  : carry/borrow passed on to the next more significant digit
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t nxt,
  output logic       cout
);

  always_comb begin
    nxt  = digit;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit >= BCD_MAX_DIGIT) begin
          nxt  = 4'd0;
          cout = 1'b1;
        end else begin
          nxt = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          nxt  = BCD_MAX_DIGIT;
          cout = 1'b1;
        end else begin
          nxt = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_nd.sv
// N-digit BCD up/down counter with programmable modulus, synchronous
// checked load, cascade carry in/out and a one-cycle load-error pulse.
//   CP     : clock, rising edge
//   CR     : asynchronous active-high reset, Q <= RST_VAL, ERR <= 0
//   bus    : slave side of bcd_counter_nd_if
//            CE/CI count enables, UP direction, LD load request,
//            D load data, MAX modulus (digits > 9 are read as 9),
//            Q count, TC terminal count, CO cascade out, ERR load error
// Edge priority: CR, then LD, then count (CE & CI), then hold.
module bcd_counter_nd
  import bcd_pkg::*;
#(
  parameter int                  DIGITS  = 4,
  parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
  input  logic            CP,
  input  logic            CR,
  bcd_counter_nd_if.slave bus
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]  q_r;
  logic          err_r;
  logic [W-1:0]  q_nxt;
  logic          err_nxt;
  logic [W-1:0]  max_eff;
  logic [W-1:0]  q_step;
  logic [DIGITS:0] carry;

  logic q_gt_max;
  logic q_ge_max;
  logic q_zero;
  logic load_ok;
  logic chain_wrap;
  logic tc;

  // Digit-serial magnitude compare, most significant digit first.
  // The first differing digit decides the result.
  function automatic logic bcd_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic decided;
    logic gt;
    decided = 1'b0;
    gt      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        decided = 1'b1;
        gt      = (a[4*i +: 4] > b[4*i +: 4]);
      end
    end
    return gt;
  endfunction

  function automatic logic all_digits_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ok = ok & bcd_valid(v[4*i +: 4]);
    end
    return ok;
  endfunction

  // MAX is sanitised per digit every cycle; it is never registered.
  always_comb begin
    max_eff = '0;
    for (int i = 0; i < DIGITS; i++) begin
      max_eff[4*i +: 4] = bcd_clamp(bus.MAX[4*i +: 4]);
    end
  end

  // Ripple chain: digit 0 always receives the +1/-1 request.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit (q_r[4*g +: 4]),
      .up    (bus.UP),
      .cin   (carry[g]),
      .nxt   (q_step[4*g +: 4]),
      .cout  (carry[g+1])
    );
  end

  // A carry/borrow out of the top digit only happens at all-nines (up)
  // or all-zeros (down); both cases are already wrap cases, so folding
  // it in keeps the wrap decision consistent with the chain.
  assign chain_wrap = carry[DIGITS];

  assign q_gt_max = bcd_gt(q_r, max_eff);
  assign q_ge_max = ~bcd_gt(max_eff, q_r);
  assign q_zero   = (q_r == '0);
  assign load_ok  = all_digits_valid(bus.D) & ~bcd_gt(bus.D, max_eff);

  always_comb begin
    q_nxt   = q_r;
    err_nxt = 1'b0;
    if (bus.LD) begin
      if (load_ok) begin
        q_nxt = bus.D;
      end else begin
        q_nxt   = '0;
        err_nxt = 1'b1;
      end
    end else if (bus.CE && bus.CI) begin
      if (bus.UP) begin
        // Also catches a Q stranded above a freshly lowered MAX.
        if (q_ge_max || chain_wrap) begin
          q_nxt = '0;
        end else begin
          q_nxt = q_step;
        end
      end else begin
        if (q_zero || chain_wrap || q_gt_max) begin
          q_nxt = max_eff;
        end else begin
          q_nxt = q_step;
        end
      end
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      q_r   <= RST_VAL;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      err_r <= err_nxt;
    end
  end

  assign tc      = bus.UP ? q_ge_max : q_zero;
  assign bus.Q   = q_r;
  assign bus.ERR = err_r;
  assign bus.TC  = tc;
  assign bus.CO  = tc & bus.CE & bus.CI & ~bus.LD;

endmodule

// File: tb/tb_bcd_counter_nd.sv
module tb_bcd_counter_nd;

  logic CP;
  logic CR;

  int checks;
  int failures;

  // Reference model state: the count as a plain integer.
  int m_q;
  bit m_err;
  // Cascade model: combined 4-digit count.
  int c_q;

  // clock / reset block
  initial CP = 1'b0;
  always #5 CP = ~CP;

  bcd_counter_nd_if #(.DIGITS(4)) bus ();
  bcd_counter_nd #(.DIGITS(4), .RST_VAL(16'h0000)) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  bcd_counter_nd_if #(.DIGITS(2)) lo_bus ();
  bcd_counter_nd_if #(.DIGITS(2)) hi_bus ();
  bcd_counter_nd #(.DIGITS(2), .RST_VAL(8'h00)) u_lo (
    .CP  (CP),
    .CR  (CR),
    .bus (lo_bus)
  );
  bcd_counter_nd #(.DIGITS(2), .RST_VAL(8'h00)) u_hi (
    .CP  (CP),
    .CR  (CR),
    .bus (hi_bus)
  );
  assign hi_bus.CI = lo_bus.CO;

  // ---------------- model helpers (plain decimal arithmetic) ----------------
  function automatic int to_int(input logic [15:0] v);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r = r + int'(v[4*i +: 4]) * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int t;
    t = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input logic [15:0] v);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int clamp_int(input logic [15:0] v);
    logic [15:0] c;
    c = v;
    for (int i = 0; i < 4; i++) if (c[4*i +: 4] > 4'd9) c[4*i +: 4] = 4'd9;
    return to_int(c);
  endfunction

  function automatic bit model_tc(input bit up, input int maxe);
    return up ? (m_q >= maxe) : (m_q == 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit ld, input logic [15:0] d, input bit ce,
                        input bit ci, input bit up, input logic [15:0] mx);
    bus.LD  = ld;
    bus.D   = d;
    bus.CE  = ce;
    bus.CI  = ci;
    bus.UP  = up;
    bus.MAX = mx;
  endtask

  // Advance one edge; the model follows the inputs the bench drove.
  task automatic drive_edge();
    int maxe;
    maxe = clamp_int(bus.MAX);
    @(posedge CP);
    m_err = 1'b0;
    if (bus.LD) begin
      if (digits_ok(bus.D) && to_int(bus.D) <= maxe) begin
        m_q = to_int(bus.D);
      end else begin
        m_q   = 0;
        m_err = 1'b1;
      end
    end else if (bus.CE && bus.CI) begin
      if (bus.UP) m_q = (m_q >= maxe) ? 0 : m_q + 1;
      else if (m_q == 0) m_q = maxe;
      else if (m_q > maxe) m_q = maxe;
      else m_q = m_q - 1;
    end
    #1;
  endtask

  task automatic cascade_edge();
    @(posedge CP);
    if (lo_bus.CE) begin
      if (lo_bus.UP) c_q = (c_q >= 9999) ? 0 : c_q + 1;
      else c_q = (c_q == 0) ? 9999 : c_q - 1;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    CR = 1'b1;
    set_in(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h9999);
    lo_bus.LD = 1'b0; lo_bus.D = 8'h00; lo_bus.CE = 1'b0; lo_bus.CI = 1'b1;
    lo_bus.UP = 1'b1; lo_bus.MAX = 8'h99;
    hi_bus.LD = 1'b0; hi_bus.D = 8'h00; hi_bus.CE = 1'b0;
    hi_bus.UP = 1'b1; hi_bus.MAX = 8'h99;
    m_q = 0; m_err = 1'b0; c_q = 0;
    #2;
    checks++;
    if (bus.Q !== 16'h0000) begin
      failures++; $display("FAIL reset_q actual=%h expected=%h", bus.Q, 16'h0000);
    end
    checks++;
    if (bus.ERR !== 1'b0) begin
      failures++; $display("FAIL reset_err actual=%b expected=0", bus.ERR);
    end
    checks++;
    if (bus.TC !== 1'b1) begin
      failures++; $display("FAIL reset_tc_down actual=%b expected=1", bus.TC);
    end
    @(negedge CP);
    CR = 1'b0;
  endtask

  task automatic test_count_up_wrap();
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0059);
    #1;
    for (int k = 1; k <= 62; k++) begin
      checks++;
      if (bus.TC !== model_tc(1'b1, 59) || bus.TC !== (m_q == 59)) begin
        failures++; $display("FAIL wrap_tc step=%0d actual=%b expected=%b", k, bus.TC, m_q == 59);
      end
      checks++;
      if (bus.CO !== (m_q == 59)) begin
        failures++; $display("FAIL wrap_co step=%0d actual=%b expected=%b", k, bus.CO, m_q == 59);
      end
      drive_edge();
      checks++;
      if (bus.Q !== to_bcd(k % 60)) begin
        failures++; $display("FAIL wrap_q step=%0d actual=%h expected=%h", k, bus.Q, to_bcd(k % 60));
      end
    end
  endtask

  task automatic test_load_updown();
    set_in(1'b1, 16'h0199, 1'b0, 1'b1, 1'b1, 16'h9999);
    drive_edge();
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h9999);
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0200) begin
      failures++; $display("FAIL ud_up actual=%h expected=0200", bus.Q);
    end
    bus.UP = 1'b0;
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0199) begin
      failures++; $display("FAIL ud_down actual=%h expected=0199", bus.Q);
    end
    set_in(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h9999);
    drive_edge();
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h9999);
    #1;
    checks++;
    if (bus.CO !== 1'b1 || bus.TC !== 1'b1) begin
      failures++; $display("FAIL ud_zero_flags actual_tc=%b actual_co=%b expected=1/1", bus.TC, bus.CO);
    end
    drive_edge();
    checks++;
    if (bus.Q !== 16'h9999) begin
      failures++; $display("FAIL ud_borrow_wrap actual=%h expected=9999", bus.Q);
    end
  endtask

  task automatic test_load_err();
    set_in(1'b1, 16'h01A3, 1'b0, 1'b1, 1'b1, 16'h9999);
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0000 || bus.ERR !== 1'b1) begin
      failures++; $display("FAIL err_bad_digit q=%h err=%b expected=0000/1", bus.Q, bus.ERR);
    end
    bus.LD = 1'b0;
    drive_edge();
    checks++;
    if (bus.ERR !== 1'b0 || bus.Q !== 16'h0000) begin
      failures++; $display("FAIL err_one_cycle q=%h err=%b expected=0000/0", bus.Q, bus.ERR);
    end
    set_in(1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, 16'h0099);
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0000 || bus.ERR !== 1'b1) begin
      failures++; $display("FAIL err_over_max q=%h err=%b expected=0000/1", bus.Q, bus.ERR);
    end
    set_in(1'b1, 16'h0042, 1'b0, 1'b1, 1'b1, 16'h0099);
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0042 || bus.ERR !== 1'b0) begin
      failures++; $display("FAIL err_good_load q=%h err=%b expected=0042/0", bus.Q, bus.ERR);
    end
  endtask

  task automatic test_max_clamp();
    set_in(1'b1, 16'h0094, 1'b0, 1'b1, 1'b1, 16'h00F5);
    drive_edge();
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00F5);
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0095 || bus.TC !== 1'b1) begin
      failures++; $display("FAIL clamp_top q=%h tc=%b expected=0095/1", bus.Q, bus.TC);
    end
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0000) begin
      failures++; $display("FAIL clamp_wrap actual=%h expected=0000", bus.Q);
    end
    set_in(1'b1, 16'h0080, 1'b0, 1'b1, 1'b1, 16'h9999);
    drive_edge();
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0050);
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0000) begin
      failures++; $display("FAIL lowered_max actual=%h expected=0000", bus.Q);
    end
    // Zero modulus: up holds at 0 with TC high, down reloads 0 with CO high.
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000);
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0000 || bus.TC !== 1'b1) begin
      failures++; $display("FAIL max0_up q=%h tc=%b expected=0000/1", bus.Q, bus.TC);
    end
    bus.UP = 1'b0;
    #1;
    checks++;
    if (bus.CO !== 1'b1) begin
      failures++; $display("FAIL max0_down_co actual=%b expected=1", bus.CO);
    end
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0000) begin
      failures++; $display("FAIL max0_down_q actual=%h expected=0000", bus.Q);
    end
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 16'h0037, 1'b0, 1'b1, 1'b1, 16'h9999);
    drive_edge();
    set_in(1'b1, 16'h0042, 1'b1, 1'b1, 1'b1, 16'h9999);
    #2;
    CR = 1'b1;
    m_q = 0; m_err = 1'b0;
    #1;
    checks++;
    if (bus.Q !== 16'h0000 || bus.ERR !== 1'b0) begin
      failures++; $display("FAIL async_rst q=%h err=%b expected=0000/0", bus.Q, bus.ERR);
    end
    @(posedge CP);
    #1;
    checks++;
    if (bus.Q !== 16'h0000) begin
      failures++; $display("FAIL rst_beats_load actual=%h expected=0000", bus.Q);
    end
    @(negedge CP);
    CR = 1'b0;
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h9999);
    drive_edge();
    checks++;
    if (bus.Q !== 16'h0001) begin
      failures++; $display("FAIL resume_after_rst actual=%h expected=0001", bus.Q);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [15:0] mx;
    int maxe;
    mx = 16'h9999;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0)
        mx = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : to_bcd($urandom_range(0, 9999));
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : to_bcd($urandom_range(0, 9999));
      set_in($urandom_range(0, 7) == 0, d, $urandom_range(0, 3) != 0,
             $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)), mx);
      maxe = clamp_int(mx);
      #1;
      checks++;
      if (bus.TC !== model_tc(bus.UP, maxe) ||
          bus.CO !== (model_tc(bus.UP, maxe) & bus.CE & bus.CI & ~bus.LD)) begin
        failures++;
        $display("FAIL rand_flags n=%0d tc=%b co=%b expected_tc=%b", n, bus.TC, bus.CO, model_tc(bus.UP, maxe));
      end
      drive_edge();
      checks++;
      if (bus.Q !== to_bcd(m_q) || bus.ERR !== m_err) begin
        failures++;
        $display("FAIL rand_q n=%0d q=%h err=%b expected=%h/%b", n, bus.Q, bus.ERR, to_bcd(m_q), m_err);
      end
    end
  endtask

  task automatic test_cascade();
    set_in(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h9999);
    lo_bus.LD = 1'b1; lo_bus.D = 8'h99; lo_bus.CE = 1'b0;
    hi_bus.LD = 1'b1; hi_bus.D = 8'h00; hi_bus.CE = 1'b0;
    @(posedge CP);
    #1;
    c_q = 99;
    lo_bus.LD = 1'b0; hi_bus.LD = 1'b0;
    lo_bus.CE = 1'b1; hi_bus.CE = 1'b1;
    lo_bus.UP = 1'b1; hi_bus.UP = 1'b1;
    cascade_edge();
    checks++;
    if ({hi_bus.Q, lo_bus.Q} !== 16'h0100) begin
      failures++; $display("FAIL casc_up actual=%h expected=0100", {hi_bus.Q, lo_bus.Q});
    end
    lo_bus.UP = 1'b0; hi_bus.UP = 1'b0;
    cascade_edge();
    checks++;
    if ({hi_bus.Q, lo_bus.Q} !== 16'h0099) begin
      failures++; $display("FAIL casc_down actual=%h expected=0099", {hi_bus.Q, lo_bus.Q});
    end
    lo_bus.CE = 1'b0; hi_bus.CE = 1'b0;
    cascade_edge();
    checks++;
    if ({hi_bus.Q, lo_bus.Q} !== 16'h0099) begin
      failures++; $display("FAIL casc_hold actual=%h expected=0099", {hi_bus.Q, lo_bus.Q});
    end
    for (int n = 0; n < 150; n++) begin
      lo_bus.CE = $urandom_range(0, 4) != 0;
      hi_bus.CE = lo_bus.CE;
      lo_bus.UP = ($urandom_range(0, 3) != 0);
      hi_bus.UP = lo_bus.UP;
      cascade_edge();
      checks++;
      if ({hi_bus.Q, lo_bus.Q} !== to_bcd(c_q)) begin
        failures++;
        $display("FAIL casc_rand n=%0d actual=%h expected=%h", n, {hi_bus.Q, lo_bus.Q}, to_bcd(c_q));
      end
    end
  endtask

  // Bound on total run time in case the design stalls the bench.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_count_up_wrap();
    test_load_updown();
    test_load_err();
    test_max_clamp();
    test_async_reset();
    test_random();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
